// File: rtl/sram_controller.sv
// sram_controller: sequences one load or store from the MEM stage onto a
// 256K x 16 asynchronous SRAM over WAIT_CYCLES access cycles. The pipeline
// is held by `freeze` until the access completes; load data is registered
// so MEM/WB captures it on the cycle `freeze` drops.
module sram_controller #(
    // Cycles spent in ACCESS; the 3-bit counter limits this to 2..7.
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        freeze,
    output logic        done,
    output logic [2:0]  counter,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_COUNT = 3'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        op_write;     // latched op: 0 = read, 1 = write
    logic [15:0] wdata_q;
    logic        dq_oe;
    logic        req;
    logic        last_cycle;

    assign req        = wr_en | rd_en;
    assign last_cycle = (counter == LAST_COUNT);

    // Data bus is only driven while a write is in ACCESS, including the
    // final hold cycle after WE rises.
    assign SRAM_DQ = dq_oe ? wdata_q : 16'hzzzz;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Next-state logic: requests are only sampled in IDLE.
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (req) next_state = S_ACCESS;
            S_ACCESS: if (last_cycle) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output logic: stall, completion pulse and SRAM strobes.
    always_comb begin
        freeze    = 1'b0;
        done      = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        case (state)
            S_IDLE: freeze = req;
            S_ACCESS: begin
                freeze    = 1'b1;
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_OE_N = op_write;
                // WE rises one cycle early to hold address/data past it.
                SRAM_WE_N = !(op_write && !last_cycle);
                dq_oe     = op_write;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: request latching, wait counter and load-data capture.
    // NOTE: these are small control/data registers, so all of them are reset;
    // read_data must read 0 after reset and SRAM_ADDR must be deterministic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter   <= 3'd0;
            op_write  <= 1'b0;
            wdata_q   <= 16'h0000;
            SRAM_ADDR <= 18'h00000;
            read_data <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_write  <= wr_en;   // write wins when both are high
                        wdata_q   <= write_data;
                        SRAM_ADDR <= {2'b00, address};
                        counter   <= 3'd0;
                    end
                end
                S_ACCESS: begin
                    counter <= counter + 3'd1;
                    if (last_cycle && !op_write) read_data <= SRAM_DQ;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the MEM stage and the external 16-bit asynchronous SRAM (256K x 16). It accepts one load or store per request from the MEM stage and sequences the SRAM strobes over a fixed number of wait cycles. While the access is in flight it asserts `freeze`, which stalls every pipeline register and the PC. It then returns load data aligned so the MEM/WB register captures it on the cycle `freeze` drops.

## Interface
Parameters:
- `WAIT_CYCLES`, default 4: number of cycles spent in ACCESS; legal range 2..7, held in a 3-bit counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  store request from MEM stage; level, held while frozen.
- `rd_en`  in  1  load request from MEM stage; level, held while frozen.
- `address`  in  16  word address from the ALU result.
- `write_data`  in  16  store data.
- `read_data`  out  16  registered load data.
- `freeze`  out  1  pipeline stall while an access is in progress.
- `done`  out  1  one-cycle pulse in the completion cycle.
- `counter`  out  3  current wait counter, exported for debug.
- `SRAM_ADDR`  out  18  SRAM address, `{2'b00, latched address}`.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  active-low SRAM strobes.

## Operation
- The FSM has three states, IDLE -> ACCESS -> DONE -> IDLE, plus a 3-bit `counter` and a latched op bit (0 = read, 1 = write).
- **IDLE**
  - If `wr_en | rd_en`: latch `address`, `write_data` and op, with write taking priority if both are high; clear `counter`; go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `counter` increments every cycle.
  - When `counter == WAIT_CYCLES-1`: go to DONE. On that same edge, if op is read, `read_data <= SRAM_DQ`.
- **DONE**: go unconditionally to IDLE. Requests are not sampled in DONE.
- `freeze = (IDLE & (wr_en | rd_en)) | ACCESS`, combinational. It is low in DONE, so the pipeline advances on the DONE edge.
- `done` = 1 only in DONE.
- SRAM strobes and data bus:
  - `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` are 0 in ACCESS and 1 otherwise.
  - `SRAM_OE_N` is 0 in ACCESS when op = read.
  - `SRAM_WE_N` is 0 in ACCESS when op = write and `counter != WAIT_CYCLES-1`. This gives one cycle of address/data hold after WE rises.
  - `SRAM_DQ` is driven with the latched write data in ACCESS when op = write. It is high-Z at all other times.
- `SRAM_ADDR` is updated only on the IDLE->ACCESS edge and holds its value afterwards.
- `read_data` holds its value until the next completed read; a write does not change it.

## Timing
- Reset values (asserted asynchronously, mid-access included):
  - State IDLE; `counter` 0.
  - `read_data` 0, `SRAM_ADDR` 0, `done` 0.
  - All SRAM strobes 1; `SRAM_DQ` high-Z.
  - `freeze` follows its equation, so it goes high in IDLE only if a request is present.
- A request seen in cycle 0 gives:
  - `freeze` high in cycles 0..WAIT_CYCLES.
  - DONE in cycle WAIT_CYCLES+1.
  - Total latency WAIT_CYCLES+2 cycles; default 6.
- Default write with WAIT_CYCLES = 4: `SRAM_WE_N` is low in cycles 1..3 and high in cycle 4; DQ is driven in cycles 1..4.
- Back-to-back memory instructions: the second request is first sampled in the IDLE cycle after DONE. There are no idle cycles in between other than DONE.
- A request deasserted in IDLE before the edge starts no access.
- Request inputs are ignored while in ACCESS, since the pipeline is frozen.

## Test plan
- **Reset:** hold `rst` = 0 with `rd_en` = 1 -> all strobes 1, `DQ` Z, `read_data` 0, `SRAM_ADDR` 0. Release -> access starts next edge.
- **Write:** `wr_en` = 1, `address` = 16'h0012, `write_data` = 16'hBEEF -> `SRAM_ADDR` = 18'h00012, `WE_N` low 3 cycles, `DQ` = BEEF for 4 cycles, `freeze` high 5 cycles, `done` pulses in cycle 5.
- **Read back:** `rd_en` at 16'h0012 with an SRAM model holding BEEF -> `OE_N` low 4 cycles, `WE_N` stays 1, `read_data` = 16'hBEEF in cycle 5, `freeze` low in cycle 5.
- **Priority and back-to-back:**
  - `wr_en` = `rd_en` = 1 -> write performed.
  - Read at 16'h0001 immediately followed by read at 16'h0002 -> two accesses separated only by DONE; `read_data` updates twice.
- **Reset mid-access:** pull `rst` low in ACCESS with `counter` = 2 -> strobes immediately 1, `DQ` Z, state IDLE, `read_data` unchanged at 0 (after reset).
- **Parameter:** WAIT_CYCLES = 2 -> `freeze` high 3 cycles, `WE_N` low exactly 1 cycle.
